acc_control_unit: RTL

Multi-cycle instruction sequencer for the accumulator CPU. It is the controlling end of the datapath interface that the accumulator and program counter consume. It fetches 16-bit instructions from memory at `pc` and decodes them. It then drives the accumulator load (`data_in`), PC advance, and `jump`/`jump_addr`, and performs operand reads and writes over a request/acknowledge memory handshake.

---
 rtl/acc_cpu_pkg.sv | 41 ++++
 rtl/acc_alu.sv | 32 +++
 rtl/acc_control_unit.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/acc_cpu_pkg.sv
// ============================================================================
// Module   : acc_cpu_pkg
// Purpose  : Shared opcode/state encodings and instruction field slices for
//            the accumulator CPU control path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package acc_cpu_pkg;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int A_HI  = 11;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_LOAD  = 4'h1,
        OP_STORE = 4'h2,
        OP_ADD   = 4'h3,
        OP_SUB   = 4'h4,
        OP_JMP   = 4'h5,
        OP_JZ    = 4'h6,
        OP_JN    = 4'h7,
        OP_HALT  = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        MEM    = 3'd2,
        EXEC   = 3'd3,
        HALT   = 3'd4
    } state_t;

    function automatic logic is_arith(input opcode_t op);
        return (op == OP_LOAD) || (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

`default_nettype wire

// File: rtl/acc_alu.sv
// ============================================================================
// Module   : acc_alu
// Purpose  : Combinational LOAD/ADD/SUB result for the accumulator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_alu
    import acc_cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  opcode_t             op_i,
    input  logic [DATA_W-1:0]   acc_i,
    input  logic [DATA_W-1:0]   operand_i,
    output logic [DATA_W-1:0]   result_o
);

    // Carry and borrow fall off the top; arithmetic wraps modulo 2^DATA_W.
    always_comb begin
        result_o = '0;
        case (op_i)
            OP_LOAD: result_o = operand_i;
            OP_ADD:  result_o = acc_i + operand_i;
            OP_SUB:  result_o = acc_i - operand_i;
            default: result_o = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/acc_control_unit.sv
// ============================================================================
// Module   : acc_control_unit
// Purpose  : Multi-cycle fetch/decode/memory/execute sequencer driving the
//            accumulator, the program counter and a req/ack memory port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_control_unit
    import acc_cpu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   pc,
    input  logic [DATA_W-1:0]   acc,
    output logic                pc_adv,
    output logic                jump,
    output logic [ADDR_W-1:0]   jump_addr,
    output logic                acc_load,
    output logic [DATA_W-1:0]   data_in,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ack,
    output logic                halted,
    output logic                illegal
);

    state_t              state_q;
    logic [DATA_W-1:0]   ir_q;
    logic [DATA_W-1:0]   opnd_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                halted_q;
    logic                illegal_q;

    opcode_t             w_op;
    logic [ADDR_W-1:0]   w_a_ext;
    logic                w_exec;
    logic                w_take;
    logic [DATA_W-1:0]   data_in_d;

    assign w_op    = opcode_t'(ir_q[OP_HI:OP_LO]);
    assign w_a_ext = ADDR_W'(ir_q[A_HI:0]);
    assign w_exec  = (state_q == EXEC);

    acc_alu #(
        .DATA_W    (DATA_W)
    ) u_alu (
        .op_i      (w_op),
        .acc_i     (acc),
        .operand_i (opnd_q),
        .result_o  (data_in_d)
    );

    // Branch decision uses acc as seen during EXEC itself.
    always_comb begin
        w_take = 1'b0;
        case (w_op)
            OP_JMP:  w_take = 1'b1;
            OP_JZ:   w_take = (acc == '0);
            OP_JN:   w_take = acc[DATA_W-1];
            default: w_take = 1'b0;
        endcase
    end

    assign jump      = w_exec & w_take;
    assign jump_addr = jump ? w_a_ext : '0;
    assign pc_adv    = w_exec & ~w_take;
    assign acc_load  = w_exec & is_arith(w_op);
    assign data_in   = acc_load ? data_in_d : '0;

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign halted    = halted_q;
    assign illegal   = illegal_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= FETCH;
            ir_q        <= '0;
            opnd_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halted_q    <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    // First cycle only sets up the request; ack is honoured once it is visible.
                    if (!mem_req_q) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= pc;
                        mem_wdata_q <= acc;
                    end else if (mem_ack) begin
                        ir_q        <= mem_rdata;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        state_q     <= DECODE;
                    end
                end
                DECODE: begin
                    case (w_op)
                        OP_NOP, OP_JMP, OP_JZ, OP_JN:
                            state_q <= EXEC;
                        OP_LOAD, OP_STORE, OP_ADD, OP_SUB:
                            state_q <= MEM;
                        OP_HALT: begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end
                        default: begin
                            illegal_q <= 1'b1;
                            halted_q  <= 1'b1;
                            state_q   <= HALT;
                        end
                    endcase
                end
                MEM: begin
                    if (!mem_req_q) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= (w_op == OP_STORE);
                        mem_addr_q  <= w_a_ext;
                        mem_wdata_q <= acc;
                    end else if (mem_ack) begin
                        opnd_q      <= mem_rdata;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= '0;
                        mem_wdata_q <= '0;
                        state_q     <= EXEC;
                    end
                end
                EXEC:    state_q <= FETCH;
                HALT:    state_q <= HALT;
                default: state_q <= FETCH;
            endcase
        end
    end

endmodule

`default_nettype wire
